rca_pipe_nb: RTL
================

// Module: rca_pipe_nb
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor. Each pipeline stage
//  ripples one CHUNK-bit slice, registers the slice sum and the carry, and
//  skews the remaining operand bits forward. It replaces fixed-width 16-bit
//  ripple adders on multi-cycle datapaths (e.g. the multiply/divide unit)
//  where a full-width ripple misses timing. It uses a valid/ready handshake
//  on both sides and supports stalls.
// PARAMETERS
//  WIDTH   16  operand/result width; must be a multiple of CHUNK (elab error otherwise)
//  CHUNK   4   bits rippled per pipeline stage; NSTAGE = WIDTH/CHUNK (>=1)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      A/B/C_in/sub valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  C_in       in   1      carry in (add mode only)
//  sub        in   1      0: S=A+B+C_in   1: S=A-B (A+~B+1, C_in ignored)
//  out_valid  out  1      S/C_out/Ofl valid
//  out_ready  in   1      consumer accepts result this cycle
//  S          out  WIDTH  sum/difference
//  C_out      out  1      carry out of MSB (for sub: 1 = no borrow)
//  Ofl        out  1      signed (two's complement) overflow
// BEHAVIOUR
//  - Reset: all stage valid bits, out_valid, S, C_out and Ofl = 0. in_ready = 1
//    while rst is low and the pipe is empty. Reset mid-operation discards all
//    in-flight operations with no output.
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Stage k (0..NSTAGE-1) adds bits [k*CHUNK +: CHUNK] with the carry
//    registered by stage k-1 (stage 0 uses C_in, or 1 when sub=1; B is
//    inverted at entry when sub=1). Lower result slices and the upper operand
//    slices travel with the op.
//  - Latency: NSTAGE cycles from the accepting edge to out_valid=1 with no
//    stall. Throughput: 1 op/cycle.
//  - Stall: stage k advances iff stage k+1 is empty or advancing. The last
//    stage advances iff out_ready | ~out_valid. Bubbles collapse.
//    in_ready = ~v[0] | advance[0]. Outputs hold stable while
//    out_valid & ~out_ready.
//  - Ordering: results leave in acceptance order. No drop and no duplicate.
//  - Ofl = carry_into_MSB ^ C_out, computed in the last stage.
//  - Wrap-around: S is the modulo-2^WIDTH result (e.g. 0xFFFF+1 -> 0x0000, C_out=1).
//  - Full pipe with out_ready=0: in_ready=0. Simultaneous in/out transfer
//    when full is allowed (occupancy unchanged).
//  - NSTAGE=1: behaves as a single registered adder with a 1-cycle latency.
// CONFIGURATION
//  RCA_PIPE_SAT_EN defined: on Ofl=1, S saturates to the signed max
//    (0x7FFF for WIDTH=16) if A is non-negative, else the signed min (0x8000).
//    Ofl and C_out are still reported unchanged.
//  RCA_PIPE_SAT_EN undefined: S is always the wrapped modulo result. There is
//    no saturation logic.
// TESTING
//  1 rst high mid-stream with 3 ops in flight -> no out_valid after release;
//    S=0, C_out=0, Ofl=0.
//  2 WIDTH=16, CHUNK=4, out_ready=1: A=0x1234, B=0x0FFF, C_in=1 ->
//    S=0x2234, C_out=0, Ofl=0, exactly 4 cycles after accept.
//  3 sub=1: A=0x0005, B=0x0007 -> S=0xFFFE, C_out=0.
//    sub=1: A=0x8000, B=0x0001 -> S=0x7FFF, Ofl=1 (0x8000 with RCA_PIPE_SAT_EN).
//  4 Back-to-back 100 random ops with random out_ready (30% low) ->
//    results match a reference model in order; outputs stable during stall;
//    in_ready=0 exactly when the pipe is full and blocked.
//  5 A=0x7FFF, B=0x0001, add -> Ofl=1, S=0x8000 (0x7FFF with RCA_PIPE_SAT_EN).
//    A=0xFFFF, B=0x0001 -> S=0x0000, C_out=1, Ofl=0.
//  6 Rerun 2 and 4 with WIDTH=32/CHUNK=8 and WIDTH=8/CHUNK=8 (NSTAGE=1) ->
//    latency equals NSTAGE and results are correct.

Source files
------------

// File: rtl/rca_pipe_nb_if.sv
// Operand/result handshake bundle for rca_pipe_nb.
// master: operand producer and result consumer; slave: the adder pipeline.
interface rca_pipe_nb_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             Ofl;

  modport master (
    output in_valid, A, B, C_in, sub, out_ready,
    input  in_ready, out_valid, S, C_out, Ofl
  );

  modport slave (
    input  in_valid, A, B, C_in, sub, out_ready,
    output in_ready, out_valid, S, C_out, Ofl
  );
endinterface

// File: rtl/rca_pipe_nb.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// Register 0 captures the operands (B pre-inverted for subtract, carry-in
// forced to 1); stage k ripples slice k of register k into register k+1;
// the last stage ripples the top slice into the output register.
// Latency is NSTAGE cycles from the accepting edge; bubbles collapse.
// Optional feature: define RCA_PIPE_SAT_EN to saturate S on signed overflow.
module rca_pipe_nb #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic          clk,
  input logic          rst,
  rca_pipe_nb_if.slave bus
);
  localparam int unsigned NSTAGE = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0 || NSTAGE < 1) begin : g_bad_cfg
    $error("rca_pipe_nb: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Stage registers: a_q holds finished result slices below the stage's
  // slice and untouched A bits above it; b_q carries the (inverted) B.
  logic [NSTAGE-1:0]            v_q;
  logic [NSTAGE-1:0][WIDTH-1:0] a_q;
  logic [NSTAGE-1:0][WIDTH-1:0] b_q;
  logic [NSTAGE-1:0]            c_q;

  logic [NSTAGE-1:0][WIDTH-1:0] a_d;
  logic [NSTAGE-1:0]            c_d;
  logic [CHUNK:0]               slice;

  logic [NSTAGE-1:0]            adv;
  logic                         out_adv;
  logic                         in_rdy;
  logic [WIDTH-1:0]             b_in;

  logic                         out_v_q;
  logic [WIDTH-1:0]             s_q;
  logic [WIDTH-1:0]             s_d;
  logic                         co_q;
  logic                         ofl_q;
  logic                         ofl_d;

  assign b_in = bus.sub ? ~bus.B : bus.B;

  // Ripple each stage's own slice with the carry it holds.
  always_comb begin
    slice = '0;
    a_d   = a_q;
    c_d   = '0;
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      slice = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
            + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, c_q[k]};
      a_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
      c_d[k] = slice[CHUNK];
    end
  end

  // Advance chain: a register moves when the next one is empty or moving.
  always_comb begin
    out_adv          = bus.out_ready | ~out_v_q;
    adv              = '0;
    adv[NSTAGE-1]    = out_adv;
    for (int unsigned i = 1; i < NSTAGE; i++) begin
      adv[NSTAGE-1-i] = ~v_q[NSTAGE-i] | adv[NSTAGE-i];
    end
    in_rdy = ~v_q[0] | adv[0];
  end

  // Final result; carry into the MSB is recovered as s^a^b at the MSB.
  always_comb begin
    s_d   = a_d[NSTAGE-1];
    ofl_d = s_d[WIDTH-1] ^ a_q[NSTAGE-1][WIDTH-1] ^ b_q[NSTAGE-1][WIDTH-1]
          ^ c_d[NSTAGE-1];
`ifdef RCA_PIPE_SAT_EN
    if (ofl_d) begin
      s_d = a_q[NSTAGE-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Pipeline registers: accept into register 0, shift forward on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      if (in_rdy) begin
        v_q[0] <= bus.in_valid;
        if (bus.in_valid) begin
          a_q[0] <= bus.A;
          b_q[0] <= b_in;
          c_q[0] <= bus.sub | bus.C_in;
        end
      end
      for (int unsigned k = 1; k < NSTAGE; k++) begin
        if (~v_q[k] | adv[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            a_q[k] <= a_d[k-1];
            b_q[k] <= b_q[k-1];
            c_q[k] <= c_d[k-1];
          end
        end
      end
    end
  end

  // Output register: holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ofl_q   <= 1'b0;
    end else if (out_adv) begin
      out_v_q <= v_q[NSTAGE-1];
      if (v_q[NSTAGE-1]) begin
        s_q   <= s_d;
        co_q  <= c_d[NSTAGE-1];
        ofl_q <= ofl_d;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_v_q;
  assign bus.S         = s_q;
  assign bus.C_out     = co_q;
  assign bus.Ofl       = ofl_q;
endmodule
